// File: rtl/fifo_hex_uart_tx_if.sv
// FIFO read-side handshake between the 16-to-8 SPRAM FIFO and its hex/UART drain.
// master: the drain that pulls bytes; slave: the FIFO that supplies them.
interface fifo_hex_uart_tx_if;
  logic       fifo_data_available;
  logic       fifo_write_strobe;
  logic [7:0] fifo_read_data;
  logic       fifo_read_strobe;

  modport master (
    input  fifo_data_available,
    input  fifo_write_strobe,
    input  fifo_read_data,
    output fifo_read_strobe
  );

  modport slave (
    output fifo_data_available,
    output fifo_write_strobe,
    output fifo_read_data,
    input  fifo_read_strobe
  );
endinterface

// File: rtl/fifo_hex_uart_tx.sv
// Drains the SPRAM FIFO byte by byte and sends each byte as two uppercase hex chars, 8N1.
// Define HEX_NEWLINE_EN to append CR/LF after every BYTES_PER_LINE bytes.
module fifo_hex_uart_tx #(
  parameter int unsigned DIVISOR        = 12,
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  fifo_hex_uart_tx_if.master fifo,
  output logic               uart_tx,
  output logic               busy
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("fifo_hex_uart_tx: DIVISOR must be in 2..65535");
  end
  if (BYTES_PER_LINE < 1 || BYTES_PER_LINE > 255) begin : g_bad_line
    $error("fifo_hex_uart_tx: BYTES_PER_LINE must be in 1..255");
  end

  typedef enum logic [2:0] {IDLE, SETTLE, HI, LO, CR, LF} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(DIVISOR - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic [3:0]  lo_nib;
  logic        fetch_ok;
  logic        bit_end;
  logic        frame_end;
  logic        load_en;
  logic [7:0]  load_char;

`ifdef HEX_NEWLINE_EN
  localparam logic [7:0] LINE_LAST = 8'(BYTES_PER_LINE - 1);
  logic [7:0] line_cnt;
  logic       line_end;
  assign line_end = (line_cnt == LINE_LAST);
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign fetch_ok  = fifo.fifo_data_available && !fifo.fifo_write_strobe;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = bit_end && (bit_cnt == 4'd9);

  // Combinational so the pointer advances in the very cycle the byte is captured.
  assign fifo.fifo_read_strobe = (state == SETTLE) && fetch_ok;

  // Next character and the moment it enters the shifter; loading on a frame's
  // last clock keeps consecutive frames gap-free.
  always_comb begin
    load_en   = 1'b0;
    load_char = '0;
    case (state)
      SETTLE: begin
        load_en   = fetch_ok;
        load_char = hex_char(fifo.fifo_read_data[7:4]);
      end
      HI: begin
        load_en   = frame_end;
        load_char = hex_char(lo_nib);
      end
`ifdef HEX_NEWLINE_EN
      LO: begin
        load_en   = frame_end && line_end;
        load_char = 8'h0D;
      end
      CR: begin
        load_en   = frame_end;
        load_char = 8'h0A;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      lo_nib   <= '0;
`ifdef HEX_NEWLINE_EN
      line_cnt <= '0;
`endif
    end else begin
      if (state != IDLE && state != SETTLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (bit_cnt != 4'd9) begin
            bit_cnt <= bit_cnt + 4'd1;
            uart_tx <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end

      // Start bit is driven at the load edge; shreg holds data LSB-first then stop.
      if (load_en) begin
        uart_tx  <= 1'b0;
        shreg    <= {1'b1, load_char};
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end

      case (state)
        IDLE: if (enable && fetch_ok) state <= SETTLE;
        SETTLE: begin
          if (fetch_ok) begin
            lo_nib <= fifo.fifo_read_data[3:0];
            busy   <= 1'b1;
            state  <= HI;
          end else begin
            state <= IDLE;
          end
        end
        HI: if (frame_end) state <= LO;
        LO: begin
          if (frame_end) begin
`ifdef HEX_NEWLINE_EN
            line_cnt <= line_cnt + 8'd1;
            if (line_end) begin
              state <= CR;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef HEX_NEWLINE_EN
        CR: if (frame_end) state <= LF;
        LF: begin
          if (frame_end) begin
            line_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_hex_uart_tx.md
Name: fifo_hex_uart_tx

Overview:
- Drain stage directly downstream of the 16-to-8 SPRAM FIFO.
- Pulls one byte at a time from the FIFO and formats it as two uppercase ASCII hex characters.
- Serialises the characters as 8N1 UART frames on a single TX pin.
- Used to dump captured trace words to a host terminal.

Parameters:
- DIVISOR, 12, clocks per UART bit; valid range 2..65535; counter width 16 bits.
- BYTES_PER_LINE, 16, bytes per output line; used only when HEX_NEWLINE_EN is defined; valid range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when high, the block may fetch new bytes from the FIFO.
- fifo_data_available  input  1  FIFO not-empty flag.
- fifo_write_strobe  input  1  FIFO write strobe; while high, fifo_read_data is invalid.
- fifo_read_data  input  8  FIFO read byte; valid one cycle after the address is stable.
- fifo_read_strobe  output  1  one-cycle pulse that advances the FIFO read pointer.
- uart_tx  output  1  serial output; idles high.
- busy  output  1  high from the capture of a byte until its last frame's stop bit ends.

Behaviour:
- Reset (asynchronous, reset low):
  - state=IDLE, uart_tx=1, fifo_read_strobe=0, busy=0.
  - Baud counter, bit counter and line counter all cleared.
  - Reset mid-frame forces uart_tx high immediately; the partial frame is abandoned.
- Main FSM states: IDLE, SETTLE, HI, LO, CR, LF.
- IDLE:
  - Go to SETTLE when enable && fifo_data_available && !fifo_write_strobe.
- SETTLE (covers the SPRAM one-cycle read latency):
  - If fifo_write_strobe is high or fifo_data_available is low: return to IDLE with no strobe.
  - Otherwise: capture fifo_read_data into the byte register, pulse fifo_read_strobe for exactly this cycle, set busy=1, go to HI.
  - At most one strobe per captured byte.
- Nibble-to-ASCII encoding:
  - n < 10 maps to 8'h30+n.
  - n >= 10 maps to 8'h37+n (A..F uppercase).
- HI: load the high-nibble character into the UART shifter; when the frame completes, go to LO.
- LO: load the low-nibble character; when the frame completes:
  - Increment the line counter.
  - Go to CR if the newline condition holds (see Optional Feature); otherwise go to IDLE.
- Frame timing and bit order:
  - Each frame is 10 bits, each lasting DIVISOR clocks: start bit 0, data bits LSB first, stop bit 1. Total 10*DIVISOR cycles.
  - The start bit appears on the cycle after the character is loaded.
  - Frames within a byte are back-to-back, with no idle gap between HI, LO, CR and LF.
- Returning to IDLE:
  - busy falls on the same cycle IDLE is entered.
  - Minimum one idle cycle plus one SETTLE cycle between bytes.
- Deasserting enable:
  - Never truncates a byte: all characters of a captured byte, including any CR/LF, are completed.
  - No new fetch occurs while enable is low.
- An empty FIFO leaves the block in IDLE with uart_tx=1 indefinitely.
- fifo_write_strobe only delays fetch; it never corrupts a captured byte.

Optional Feature:
- Macro: HEX_NEWLINE_EN.
- Defined:
  - When the line counter reaches BYTES_PER_LINE after LO, go CR (send 8'h0D), then LF (send 8'h0A), then clear the line counter and return to IDLE.
  - busy stays high through LF.
- Undefined:
  - CR/LF states and the line counter are not synthesised.
  - Output is a continuous hex stream; LO always returns to IDLE.

Test Plan:
- Single byte: DIVISOR=4, FIFO holds 8'h3A, enable=1.
  - Exactly one fifo_read_strobe pulse.
  - uart_tx carries 8'h33 then 8'h41, each frame 40 cycles, contiguous.
  - busy is high for 80 cycles, then the FSM returns to IDLE.
- Nibble edges: bytes 8'h09 and 8'hF0.
  - Characters sent: "0","9","F","0" (8'h30,8'h39,8'h46,8'h30).
- Write collision: fifo_write_strobe high on the SETTLE cycle.
  - No strobe, no capture, return to IDLE.
  - Retry on the next free cycles captures the correct byte.
- enable dropped mid-HI frame with 3 bytes queued.
  - Both characters of the current byte complete.
  - No further strobes while enable=0.
  - Resumes on re-enable.
- Asynchronous reset asserted mid-LO frame.
  - uart_tx=1 and busy=0 in the same cycle, state=IDLE.
  - After release, the next queued byte transmits cleanly.
- HEX_NEWLINE_EN defined, BYTES_PER_LINE=2, bytes 8'h01, 8'h02.
  - Stream sent: "0102" then 8'h0D, 8'h0A.
  - The line counter then restarts.
